// File: rtl/instr_encoder.sv
// Packs CU instruction fields into a 32-bit word and writes it to the next
// sequential program-memory address; illegal field sets are rejected and counted.
module instr_encoder #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   data_in,
    input  logic [4:0]    addr1_in,
    input  logic          rd_in,
    input  logic          wr_in,
    input  logic          ldi_in,
    input  logic [3:0]    opcode_in,
    input  logic [3:0]    flags_in,
    input  logic          clear,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ack,
    output logic          full,
    output logic          err,
    output logic [7:0]    err_count,
    output logic [AW:0]   wr_count
);

    localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StEncode, StWrite, StFull} state_e;

    state_e        r_state;
    state_e        w_state_next;

    logic [15:0]   r_data;
    logic [4:0]    r_addr1;
    logic          r_rd;
    logic          r_wr;
    logic          r_ldi;
    logic [3:0]    r_opcode;
    logic [3:0]    r_flags;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_wr_count;
    logic [AW-1:0] r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic          r_err;
    logic [7:0]    r_err_count;

    logic [31:0]   w_word;
    logic          w_illegal;
    logic [AW:0]   w_count_inc;

    assign w_word      = {r_data, r_addr1, r_rd, r_wr, r_ldi, r_opcode, r_flags};
    assign w_illegal   = (r_rd & r_wr) | (r_ldi & (r_rd | r_wr));
    assign w_count_inc = r_wr_count + 1'b1;

    // Clear takes priority over a new field set in the same IDLE cycle.
    assign in_ready  = (r_state == StIdle) && !clear;
    assign mem_we    = (r_state == StWrite);
    assign full      = (r_state == StFull);
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign err       = r_err;
    assign err_count = r_err_count;
    assign wr_count  = r_wr_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (!clear && in_valid) begin
                    w_state_next = StEncode;
                end
            end
            StEncode: w_state_next = w_illegal ? StIdle : StWrite;
            StWrite: begin
                if (mem_ack) begin
                    w_state_next = (w_count_inc == DepthCnt) ? StFull : StIdle;
                end
            end
            StFull: begin
                if (clear) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data      <= '0;
            r_addr1     <= '0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_ldi       <= 1'b0;
            r_opcode    <= '0;
            r_flags     <= '0;
            r_wr_ptr    <= '0;
            r_wr_count  <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_err <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (clear) begin
                        r_wr_ptr   <= '0;
                        r_wr_count <= '0;
                    end else if (in_valid) begin
                        r_data   <= data_in;
                        r_addr1  <= addr1_in;
                        r_rd     <= rd_in;
                        r_wr     <= wr_in;
                        r_ldi    <= ldi_in;
                        r_opcode <= opcode_in;
                        r_flags  <= flags_in;
                    end
                end
                StEncode: begin
                    if (w_illegal) begin
                        r_err <= 1'b1;
                        if (r_err_count != 8'hFF) begin
                            r_err_count <= r_err_count + 8'd1;
                        end
                    end else begin
                        r_mem_wdata <= w_word;
                        r_mem_addr  <= r_wr_ptr;
                    end
                end
                StWrite: begin
                    // Pointer wraps to 0 on its own once DEPTH words are written.
                    if (mem_ack) begin
                        r_wr_ptr   <= r_wr_ptr + 1'b1;
                        r_wr_count <= w_count_inc;
                    end
                end
                StFull: begin
                    if (clear) begin
                        r_wr_ptr   <= '0;
                        r_wr_count <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder (DEPTH=4); completed writes are checked
// against a queue of expected {addr, word} pushed when each field set is sent.
module tb_instr_encoder;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   data_in;
    logic [4:0]    addr1_in;
    logic          rd_in;
    logic          wr_in;
    logic          ldi_in;
    logic [3:0]    opcode_in;
    logic [3:0]    flags_in;
    logic          clear;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ack;
    logic          full;
    logic          err;
    logic [7:0]    err_count;
    logic [AW:0]   wr_count;

    int checks = 0;
    int errors = 0;

    logic [AW+31:0] sb[$];
    logic [AW-1:0]  exp_ptr = '0;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .addr1_in  (addr1_in),
        .rd_in     (rd_in),
        .wr_in     (wr_in),
        .ldi_in    (ldi_in),
        .opcode_in (opcode_in),
        .flags_in  (flags_in),
        .clear     (clear),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .full      (full),
        .err       (err),
        .err_count (err_count),
        .wr_count  (wr_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one field set; returns #1 after the accepting edge (DUT in ENCODE).
    task automatic send(input logic [15:0] d, input logic [4:0] a1, input logic rd,
                        input logic wr, input logic ldi, input logic [3:0] op,
                        input logic [3:0] fl);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 100) begin
            check("send_timeout", 64'd0, 64'd1);
        end
        data_in   = d;
        addr1_in  = a1;
        rd_in     = rd;
        wr_in     = wr;
        ldi_in    = ldi;
        opcode_in = op;
        flags_in  = fl;
        in_valid  = 1'b1;
        if (!((rd & wr) | (ldi & (rd | wr)))) begin
            sb.push_back({exp_ptr, d, a1, rd, wr, ldi, op, fl});
            exp_ptr = exp_ptr + 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Scoreboard: every completed write must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && mem_we && mem_ack) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_write", 64'd1, 64'd0);
            end else begin
                logic [AW+31:0] e;
                e = sb.pop_front();
                check("sb_addr", 64'(mem_addr), 64'(e[AW+31:32]));
                check("sb_wdata", 64'(mem_wdata), 64'(e[31:0]));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0; mem_ack = 1'b1;
        data_in = '0; addr1_in = '0; rd_in = 1'b0; wr_in = 1'b0; ldi_in = 1'b0;
        opcode_in = '0; flags_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        check("rst_wr_count", 64'(wr_count), 64'd0);
        rst_n = 1'b1;

        // Basic legal word, zero-wait ack.
        send(16'hABCD, 5'd3, 1'b1, 1'b0, 1'b0, 4'h2, 4'h1);
        @(negedge clk);
        check("t1_we_n1", 64'(mem_we), 64'd0);
        @(negedge clk);
        check("t1_we_n2", 64'(mem_we), 64'd1);
        check("t1_addr", 64'(mem_addr), 64'd0);
        check("t1_wdata", 64'(mem_wdata), 64'hABCD_1C21);
        check("t1_ready_busy", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("t1_we_done", 64'(mem_we), 64'd0);
        check("t1_wr_count", 64'(wr_count), 64'd1);
        check("t1_ready", 64'(in_ready), 64'd1);

        // Illegal sets: rd&wr, then ldi&rd.
        send(16'h1111, 5'd1, 1'b1, 1'b1, 1'b0, 4'h3, 4'h0);
        @(negedge clk);
        check("t2_err_pre", 64'(err), 64'd0);
        @(negedge clk);
        check("t2_err", 64'(err), 64'd1);
        check("t2_err_count", 64'(err_count), 64'd1);
        check("t2_no_we", 64'(mem_we), 64'd0);
        @(negedge clk);
        check("t2_err_post", 64'(err), 64'd0);
        check("t2_wr_count", 64'(wr_count), 64'd1);
        send(16'h2222, 5'd2, 1'b1, 1'b0, 1'b1, 4'h4, 4'h0);
        repeat (2) @(negedge clk);
        check("t2_err_count2", 64'(err_count), 64'd2);

        // Ack held low for 5 cycles in WRITE.
        mem_ack = 1'b0;
        send(16'h5A5A, 5'd31, 1'b0, 1'b1, 1'b0, 4'hF, 4'hE);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_we_hold", 64'(mem_we), 64'd1);
            check("t3_addr_hold", 64'(mem_addr), 64'd1);
            check("t3_wdata_hold", 64'(mem_wdata), 64'h5A5A_FAFE);
            check("t3_ready_busy", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1 mem_ack = 1'b1;
        repeat (2) @(negedge clk);
        check("t3_we_done", 64'(mem_we), 64'd0);
        check("t3_ready", 64'(in_ready), 64'd1);
        check("t3_wr_count", 64'(wr_count), 64'd2);

        // Reset while a write waits for ack.
        mem_ack = 1'b0;
        send(16'hDEAD, 5'd7, 1'b0, 1'b0, 1'b1, 4'h1, 4'h5);
        repeat (2) @(negedge clk);
        check("t5_we_pending", 64'(mem_we), 64'd1);
        check("t5_addr_pending", 64'(mem_addr), 64'd2);
        rst_n = 1'b0;
        sb.delete();
        exp_ptr = '0;
        @(posedge clk);
        #1;
        check("t5_rst_we", 64'(mem_we), 64'd0);
        check("t5_rst_addr", 64'(mem_addr), 64'd0);
        check("t5_rst_wdata", 64'(mem_wdata), 64'd0);
        check("t5_rst_wr_count", 64'(wr_count), 64'd0);
        check("t5_rst_err_count", 64'(err_count), 64'd0);
        check("t5_rst_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        mem_ack = 1'b1;
        send(16'h0001, 5'd0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        repeat (3) @(negedge clk);
        check("t5_wr_count", 64'(wr_count), 64'd1);

        // Fill all DEPTH words, then clear.
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        exp_ptr = '0;
        check("t4_clear_count", 64'(wr_count), 64'd0);
        for (int i = 0; i < 4; i++) begin
            send(16'h1000 + 16'(i), 5'(i), 1'b1, 1'b0, 1'b0, 4'(i), 4'hA);
            repeat (3) @(negedge clk);
        end
        check("t4_full", 64'(full), 64'd1);
        check("t4_ready_full", 64'(in_ready), 64'd0);
        check("t4_wr_count", 64'(wr_count), 64'd4);
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("t4_full_hold", 64'(full), 64'd1);
        check("t4_full_no_we", 64'(mem_we), 64'd0);
        in_valid = 1'b0;
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        exp_ptr = '0;
        @(negedge clk);
        check("t4_unfull", 64'(full), 64'd0);
        check("t4_count0", 64'(wr_count), 64'd0);
        check("t4_ready", 64'(in_ready), 64'd1);
        send(16'hBEEF, 5'd9, 1'b0, 1'b1, 1'b0, 4'h7, 4'h3);
        repeat (3) @(negedge clk);
        check("t4_wr_count1", 64'(wr_count), 64'd1);

        // Error counter saturation, then clear racing in_valid.
        for (int i = 0; i < 256; i++) begin
            send(16'(i), 5'd0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
            repeat (2) @(negedge clk);
        end
        check("t6_err_last", 64'(err), 64'd1);
        check("t6_err_sat", 64'(err_count), 64'd255);
        data_in = 16'h7777; rd_in = 1'b1; wr_in = 1'b0; ldi_in = 1'b0;
        clear = 1'b1;
        in_valid = 1'b1;
        #1;
        check("t6_ready_clear", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        in_valid = 1'b0;
        exp_ptr = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_no_we", 64'(mem_we), 64'd0);
        end
        check("t6_err_kept", 64'(err_count), 64'd255);
        check("t6_wr_count", 64'(wr_count), 64'd0);
        check("t6_ready", 64'(in_ready), 64'd1);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
